// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver.
// Each good frame updates data_out and produces a one-cycle data_ready
// strobe. A frame whose stop bit is sampled low produces a one-cycle
// frame_error strobe and leaves data_out untouched. The stop bit is
// sampled mid-bit and the FSM returns to IDLE immediately, so back-to-back
// frames are received without loss.

module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       frame_error,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             rx_meta;
    logic             rx_s;
    logic             rx_d;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       idx;
    logic [2:0]       idx_next;
    logic [7:0]       sh;
    logic [7:0]       sh_next;
    logic [7:0]       data_out_next;
    logic             data_ready_next;
    logic             frame_error_next;

    // Two-stage synchronizer on the asynchronous line plus a delayed copy for
    // falling-edge detection; all stages reset to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // State, datapath and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            sh          <= '0;
            data_out    <= 8'h00;
            data_ready  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            sh          <= sh_next;
            data_out    <= data_out_next;
            data_ready  <= data_ready_next;
            frame_error <= frame_error_next;
        end
    end

    // Next-state and datapath decisions: start on a falling edge only, verify
    // the start bit at half-bit, sample each data bit and the stop bit mid-bit.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        idx_next         = idx;
        sh_next          = sh;
        data_out_next    = data_out;
        data_ready_next  = 1'b0;
        frame_error_next = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s && rx_d) begin
                    cnt_next   = '0;
                    state_next = START;
                end
            end

            START: begin
                if (cnt == CNT_HALF_END) begin
                    if (!rx_s) begin
                        cnt_next   = '0;
                        idx_next   = '0;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_next = '0;
                    sh_next  = {rx_s, sh[7:1]};
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            STOP: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rx_s) begin
                        data_out_next   = sh;
                        data_ready_next = 1'b1;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
